// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash read responder.
package spi_flash_pkg;

  localparam int FLASH_ADDR_W = 24;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STATUS,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus rise/fall pulses
// derived from the synchronized copy.
module spi_input_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating the read side of a serial NOR flash
// (READ / RDID / RDSR), backed by a 32-bit word RAM with 1-cycle latency.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter logic [23:0] JEDEC_ID       = 24'hEF4018
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      spi_sck_i,
  input  logic                      spi_csn_i,
  input  logic                      spi_mosi_i,
  output logic                      spi_miso_o,
  output logic                      mem_en_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]               mem_rdata_i,
  output logic                      busy_o
);

  logic sck_s, sck_rise, sck_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic sck_s_unused;

  spi_input_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_sck_i),
    .q_o    (sck_s_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b1)) u_sync_csn (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_csn_i),
    .q_o    (csn_s),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_mosi_i),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  assign sck_s = sck_s_unused;

  state_e                    state_q, state_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [22:0]               shift_in_q, shift_in_d;
  logic [FLASH_ADDR_W-1:0]   flash_addr_q, flash_addr_d;
  logic [31:0]               word_q, word_d;
  logic [7:0]                tx_q, tx_d;
  logic [2:0]                tx_cnt_q, tx_cnt_d;
  logic [1:0]                id_idx_q, id_idx_d;
  logic                      miso_q, miso_d;
  logic                      mem_en_q, mem_en_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      rd_pending_q, rd_pending_d;

  logic [23:0]               rx_word;
  logic [FLASH_ADDR_W-1:0]   next_addr;
  logic [7:0]                resp_byte;

  assign rx_word   = {shift_in_q, mosi_s};
  assign next_addr = flash_addr_q + 24'd1;

  always_comb begin
    resp_byte = 8'hFF;
    case (state_q)
      DATA:   resp_byte = word_q[{flash_addr_q[1:0], 3'b000} +: 8];
      STATUS: resp_byte = 8'h00;
      ID: begin
        case (id_idx_q)
          2'd0:    resp_byte = JEDEC_ID[23:16];
          2'd1:    resp_byte = JEDEC_ID[15:8];
          2'd2:    resp_byte = JEDEC_ID[7:0];
          default: resp_byte = 8'hFF;
        endcase
      end
      default: resp_byte = 8'hFF;
    endcase
  end

  // Chip-select edges take priority over sck edges seen in the same cycle.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_in_d   = shift_in_q;
    flash_addr_d = flash_addr_q;
    word_d       = word_q;
    tx_d         = tx_q;
    tx_cnt_d     = tx_cnt_q;
    id_idx_d     = id_idx_q;
    miso_d       = miso_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    rd_pending_d = mem_en_q;

    if (rd_pending_q) begin
      word_d = mem_rdata_i;
    end

    if (csn_rise) begin
      state_d    = IDLE;
      bit_cnt_d  = 5'd0;
      shift_in_d = 23'd0;
      tx_d       = 8'd0;
      tx_cnt_d   = 3'd0;
      id_idx_d   = 2'd0;
      miso_d     = 1'b1;
    end else if (csn_fall) begin
      state_d    = CMD;
      bit_cnt_d  = 5'd0;
      shift_in_d = 23'd0;
      tx_cnt_d   = 3'd0;
      id_idx_d   = 2'd0;
    end else if (sck_rise) begin
      case (state_q)
        CMD: begin
          shift_in_d = rx_word[22:0];
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d  = 5'd0;
            shift_in_d = 23'd0;
            case (rx_word[7:0])
              OP_READ: state_d = ADDR;
              OP_RDID: state_d = ID;
              OP_RDSR: state_d = STATUS;
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          shift_in_d = rx_word[22:0];
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d    = 5'd0;
            flash_addr_d = rx_word;
            mem_en_d     = 1'b1;
            mem_addr_d   = rx_word[MEM_ADDR_WIDTH+1:2];
            state_d      = DATA;
          end
        end
        default: ;
      endcase
    end else if (sck_fall && (state_q == DATA || state_q == ID || state_q == STATUS)) begin
      tx_cnt_d = tx_cnt_q + 3'd1;
      if (tx_cnt_q == 3'd0) begin
        miso_d = resp_byte[7];
        tx_d   = {resp_byte[6:0], 1'b0};
        // Loading the last byte of a word fetches the next one well ahead of use.
        if (state_q == DATA) begin
          flash_addr_d = next_addr;
          if (flash_addr_q[1:0] == 2'd3) begin
            mem_en_d   = 1'b1;
            mem_addr_d = next_addr[MEM_ADDR_WIDTH+1:2];
          end
        end
        if (state_q == ID && id_idx_q != 2'd3) begin
          id_idx_d = id_idx_q + 2'd1;
        end
      end else begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 5'd0;
      shift_in_q   <= 23'd0;
      flash_addr_q <= '0;
      word_q       <= 32'd0;
      tx_q         <= 8'd0;
      tx_cnt_q     <= 3'd0;
      id_idx_q     <= 2'd0;
      miso_q       <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_in_q   <= shift_in_d;
      flash_addr_q <= flash_addr_d;
      word_q       <= word_d;
      tx_q         <= tx_d;
      tx_cnt_q     <= tx_cnt_d;
      id_idx_q     <= id_idx_d;
      miso_q       <= miso_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign spi_miso_o = miso_q;
  assign mem_en_o   = mem_en_q;
  assign mem_addr_o = mem_addr_q;
  assign busy_o     = ~csn_s;

  logic unused_sck_level;
  assign unused_sck_level = sck_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboarded bench for spi_flash_responder: an SPI initiator drives
// transactions, monitors compare MISO bytes and RAM strobes against a model.
module tb_spi_flash_responder;

  localparam int          H     = 5;
  localparam logic [23:0] JEDEC = 24'hEF4018;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .MEM_ADDR_WIDTH (14),
    .JEDEC_ID       (JEDEC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .spi_sck_i   (sck),
    .spi_csn_i   (csn),
    .spi_mosi_i  (mosi),
    .spi_miso_o  (miso),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  logic [31:0] ram [0:16383];

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_bytes[$];
  logic [13:0] exp_mem[$];
  int          exp_hdr[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flash byte a lives in RAM word a/4 (aliased), little-endian.
  function automatic logic [7:0] flashByte(input int a);
    int idx;
    idx = (a / 4) % 16384;
    return 8'(ram[idx] >> (8 * (a % 4)));
  endfunction

  function automatic logic [13:0] wordOf(input int a);
    return 14'((a / 4) % 16384);
  endfunction

  task automatic expectRead(input int addr, input int n);
    int a;
    exp_hdr.push_back(32);
    exp_mem.push_back(wordOf(addr));
    for (int i = 0; i < n; i++) begin
      a = (addr + i) % (1 << 24);
      exp_bytes.push_back(flashByte(a));
      if (a % 4 == 3) exp_mem.push_back(wordOf((a + 1) % (1 << 24)));
    end
  endtask

  task automatic sendBit(input logic b);
    sck  = 1'b0;
    mosi = b;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic endXfer();
    sck = 1'b0;
    csn = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("busy_fall", 32'(busy), 32'd0);
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [23:0] addr,
                               input int naddr, input int ndata, input bit finish_xfer);
    @(negedge clk);
    csn = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 7; i >= 0; i--) sendBit(op[i]);
    for (int i = 0; i < naddr; i++) sendBit(addr[23 - i]);
    for (int i = 0; i < ndata; i++) sendBit(1'($urandom_range(0, 1)));
    checkOutput("busy_active", 32'(busy), 32'd1);
    if (finish_xfer) endXfer();
  endtask

  task automatic doRead(input int addr, input int n);
    expectRead(addr, n);
    applyStimulus(8'h03, 24'(addr), 24, 8 * n, 1'b1);
  endtask

  task automatic doId(input int n);
    exp_hdr.push_back(8);
    for (int i = 0; i < n; i++)
      exp_bytes.push_back(i < 3 ? 8'(JEDEC >> (8 * (2 - i))) : 8'hFF);
    applyStimulus(8'h9F, 24'd0, 0, 8 * n, 1'b1);
  endtask

  task automatic doStatus(input int n);
    exp_hdr.push_back(8);
    for (int i = 0; i < n; i++) exp_bytes.push_back(8'h00);
    applyStimulus(8'h05, 24'd0, 0, 8 * n, 1'b1);
  endtask

  // MISO monitor: skips header bits, assembles response bytes, checks each one.
  initial begin
    int hdr;
    int cnt;
    logic [7:0] sh;
    forever begin
      @(negedge csn);
      if (exp_hdr.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL xfer_hdr: got unexpected transfer, expected none");
        hdr = 0;
      end else begin
        hdr = exp_hdr.pop_front();
      end
      cnt = 0;
      sh  = 8'd0;
      forever begin
        @(posedge sck or posedge csn);
        if (csn) break;
        cnt++;
        if (cnt > hdr) begin
          sh = {sh[6:0], miso};
          if ((cnt - hdr) % 8 == 0) begin
            if (exp_bytes.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL miso_byte: got 0x%0h, expected no byte", sh);
            end else begin
              checkOutput("miso_byte", 32'(sh), 32'(exp_bytes.pop_front()));
            end
          end
        end
      end
    end
  end

  // RAM strobe monitor.
  always @(negedge clk) begin
    if (rst_n && mem_en !== 1'b0) begin
      if (exp_mem.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mem_en: got strobe addr 0x%0h, expected none", mem_addr);
      end else begin
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_mem.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    for (int i = 0; i < 16384; i++) ram[i] = $urandom;
    ram[0] = 32'h44332211;
    ram[1] = 32'h88776655;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_miso", 32'(miso), 32'd1);
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] directed transfers");
    doRead(0, 8);
    doRead(3, 2);
    doId(4);
    doStatus(2);

    exp_hdr.push_back(8);
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'hFF);
    applyStimulus(8'hAB, 24'd0, 0, 16, 1'b1);
    doRead(0, 1);

    exp_hdr.push_back(11);
    applyStimulus(8'h03, 24'd0, 3, 0, 1'b1);
    doRead(4, 1);

    $display("[TB] reset mid-transfer");
    expectRead(8, 2);
    applyStimulus(8'h03, 24'd8, 24, 16, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_miso", 32'(miso), 32'd1);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    endXfer();
    doRead(0, 1);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          if ($urandom_range(0, 2) == 0) a = 24'hFFFFF8 + $urandom_range(0, 7);
          else a = int'($urandom_range(0, 24'hFFFFFF));
          doRead(a, $urandom_range(1, 10));
        end
        2: doId($urandom_range(1, 5));
        default: doStatus($urandom_range(1, 3));
      endcase
    end

    repeat (20) @(negedge clk);
    checkOutput("left_bytes", 32'(exp_bytes.size()), 32'd0);
    checkOutput("left_mem", 32'(exp_mem.size()), 32'd0);
    checkOutput("left_hdr", 32'(exp_hdr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
